// File: rtl/ps2_key_decoder_if.sv
// Scan-code input, ASCII FIFO read port and key-state outputs of ps2_key_decoder.
interface ps2_key_decoder_if #(
   parameter int CNT_W = 8
);
   logic             code_valid;
   logic [7:0]       code;
   logic             rd_en;
   logic [7:0]       ascii_out;
   logic             ascii_valid;
   logic             fifo_full;
   logic             overflow;
   logic             key_down;
   logic [7:0]       held_code;
   logic             shift_held;
   logic [CNT_W-1:0] press_count;

   modport master (
      output code_valid, code, rd_en,
      input  ascii_out, ascii_valid, fifo_full, overflow,
             key_down, held_code, shift_held, press_count
   );

   modport slave (
      input  code_valid, code, rd_en,
      output ascii_out, ascii_valid, fifo_full, overflow,
             key_down, held_code, shift_held, press_count
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, typematic suppression, ASCII FWFT FIFO.
// Optional macro PS2_SHIFT_CASE_EN: lowercase letters and shifted digit symbols.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             clrn,
   ps2_key_decoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t           state;
   logic             shift_held;
   logic             key_down;
   logic [7:0]       held_code;
   logic [CNT_W-1:0] press_count;

   // Returns {mapped, ascii}; letters uppercase, digits unshifted.
   function automatic logic [8:0] map_code(input logic [7:0] sc);
      logic [8:0] r;
      r = 9'h000;
      case (sc)
         8'h1C: r = {1'b1, 8'h41};  8'h32: r = {1'b1, 8'h42};
         8'h21: r = {1'b1, 8'h43};  8'h23: r = {1'b1, 8'h44};
         8'h24: r = {1'b1, 8'h45};  8'h2B: r = {1'b1, 8'h46};
         8'h34: r = {1'b1, 8'h47};  8'h33: r = {1'b1, 8'h48};
         8'h43: r = {1'b1, 8'h49};  8'h3B: r = {1'b1, 8'h4A};
         8'h42: r = {1'b1, 8'h4B};  8'h4B: r = {1'b1, 8'h4C};
         8'h3A: r = {1'b1, 8'h4D};  8'h31: r = {1'b1, 8'h4E};
         8'h44: r = {1'b1, 8'h4F};  8'h4D: r = {1'b1, 8'h50};
         8'h15: r = {1'b1, 8'h51};  8'h2D: r = {1'b1, 8'h52};
         8'h1B: r = {1'b1, 8'h53};  8'h2C: r = {1'b1, 8'h54};
         8'h3C: r = {1'b1, 8'h55};  8'h2A: r = {1'b1, 8'h56};
         8'h1D: r = {1'b1, 8'h57};  8'h22: r = {1'b1, 8'h58};
         8'h35: r = {1'b1, 8'h59};  8'h1A: r = {1'b1, 8'h5A};
         8'h45: r = {1'b1, 8'h30};  8'h16: r = {1'b1, 8'h31};
         8'h1E: r = {1'b1, 8'h32};  8'h26: r = {1'b1, 8'h33};
         8'h25: r = {1'b1, 8'h34};  8'h2E: r = {1'b1, 8'h35};
         8'h36: r = {1'b1, 8'h36};  8'h3D: r = {1'b1, 8'h37};
         8'h3E: r = {1'b1, 8'h38};  8'h46: r = {1'b1, 8'h39};
         8'h29: r = {1'b1, 8'h20};  8'h5A: r = {1'b1, 8'h0D};
         8'h66: r = {1'b1, 8'h08};
         default: r = 9'h000;
      endcase
      return r;
   endfunction

`ifdef PS2_SHIFT_CASE_EN
   function automatic logic [7:0] apply_shift(input logic [7:0] c, input logic shift);
      logic [7:0] r;
      r = c;
      if (c >= 8'h41 && c <= 8'h5A) begin
         r = shift ? c : c + 8'h20;
      end else if (shift) begin
         case (c)
            8'h31: r = 8'h21;  8'h32: r = 8'h40;  8'h33: r = 8'h23;
            8'h34: r = 8'h24;  8'h35: r = 8'h25;  8'h36: r = 8'h5E;
            8'h37: r = 8'h26;  8'h38: r = 8'h2A;  8'h39: r = 8'h28;
            8'h30: r = 8'h29;
            default: r = c;
         endcase
      end
      return r;
   endfunction
`endif

   // Stage p0: classify the incoming byte against the current key state
   logic [8:0] dec_p0;
   logic [7:0] char_p0;
   logic       is_shift_p0;
   logic       make_p0;
   logic       push_req_p0;

   always_comb begin
      dec_p0      = map_code(bus.code);
`ifdef PS2_SHIFT_CASE_EN
      char_p0     = apply_shift(dec_p0[7:0], shift_held);
`else
      char_p0     = dec_p0[7:0];
`endif
      is_shift_p0 = (bus.code == SC_LSHIFT) || (bus.code == SC_RSHIFT);
      make_p0     = bus.code_valid && (state == IDLE) && dec_p0[8];
      push_req_p0 = make_p0 && !(key_down && (bus.code == held_code));
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state       <= IDLE;
         shift_held  <= 1'b0;
         key_down    <= 1'b0;
         held_code   <= 8'h00;
         press_count <= '0;
      end else if (bus.code_valid) begin
         case (state)
            IDLE: begin
               if (bus.code == SC_EXT) begin
                  state <= EXT;
               end else if (bus.code == SC_BRK) begin
                  state <= BRK;
               end else if (is_shift_p0) begin
                  shift_held <= 1'b1;
               end else if (push_req_p0) begin
                  held_code   <= bus.code;
                  key_down    <= 1'b1;
                  press_count <= press_count + CNT_W'(1);
               end
            end
            BRK: begin
               if (is_shift_p0) shift_held <= 1'b0;
               if (bus.code == held_code) begin
                  key_down  <= 1'b0;
                  held_code <= 8'h00;
               end
               state <= IDLE;
            end
            EXT:     state <= (bus.code == SC_BRK) ? EXT_BRK : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p1: registered decoded character waiting to enter the FIFO
   logic       vld_p1;
   logic [7:0] char_p1;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) vld_p1 <= 1'b0;
      else       vld_p1 <= push_req_p0;
   end

   always_ff @(posedge clk) begin
      char_p1 <= char_p0;
   end

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push;
   logic        overflow;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = bus.rd_en && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
   assign push  = vld_p1 && (!full || pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         if (vld_p1 && full && !pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= char_p1;
   end

   assign bus.ascii_out   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign bus.ascii_valid = !empty;
   assign bus.fifo_full   = full;
   assign bus.overflow    = overflow;
   assign bus.key_down    = key_down;
   assign bus.held_code   = held_code;
   assign bus.shift_held  = shift_held;
   assign bus.press_count = press_count;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus randomized bytes against a queue model.
module tb_ps2_key_decoder;
   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
`ifdef PS2_SHIFT_CASE_EN
   localparam bit SHIFT_CASE = 1'b1;
`else
   localparam bit SHIFT_CASE = 1'b0;
`endif

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   ps2_key_decoder_if #(.CNT_W(CNT_W)) bus ();
   ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .clrn(clrn),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: prefix mode 0=none 1=break 2=extended 3=extended-break
   int         m_mode;
   bit         m_shift;
   bit         m_key;
   logic [7:0] m_held;
   int         m_cnt;
   bit         m_ovf;
   logic [7:0] q[$];

   logic [7:0] let_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] dig_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   string      shifted_digits = ")!@#$%^&*(";
   logic [7:0] pool[16] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66,
                            8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'hE1, 8'h75, 8'hF0};

   function automatic int lookup(input logic [7:0] b, input bit sh);
      for (int i = 0; i < 26; i++)
         if (b == let_codes[i]) return (SHIFT_CASE && !sh) ? 8'h61 + i : 8'h41 + i;
      for (int i = 0; i < 10; i++)
         if (b == dig_codes[i]) return (SHIFT_CASE && sh) ? int'(shifted_digits[i]) : 8'h30 + i;
      if (b == 8'h29) return 8'h20;
      if (b == 8'h5A) return 8'h0D;
      if (b == 8'h66) return 8'h08;
      return -1;
   endfunction

   task automatic model_byte(input logic [7:0] b, input bit pop);
      int ch = -1;
      case (m_mode)
         0: begin
            if (b == 8'hE0) m_mode = 2;
            else if (b == 8'hF0) m_mode = 1;
            else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
            else begin
               ch = lookup(b, m_shift);
               if (ch >= 0) begin
                  if (m_key && b == m_held) ch = -1;
                  else begin
                     m_held = b;
                     m_key  = 1'b1;
                     m_cnt++;
                  end
               end
            end
         end
         1: begin
            if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
            if (b == m_held) begin
               m_key  = 1'b0;
               m_held = 8'h00;
            end
            m_mode = 0;
         end
         2: m_mode = (b == 8'hF0) ? 3 : 0;
         default: m_mode = 0;
      endcase
      if (pop && q.size() > 0) void'(q.pop_front());
      if (ch >= 0) begin
         if (q.size() < DEPTH) q.push_back(8'(ch));
         else m_ovf = 1'b1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clrn = 1'b0;
      bus.code_valid = 1'b0;
      bus.rd_en = 1'b0;
      bus.code = 8'h00;
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
      m_mode = 0; m_shift = 0; m_key = 0; m_held = 8'h00; m_cnt = 0; m_ovf = 0;
      q.delete();
   endtask

   // Byte sampled on edge N; rd_en (if pop) sampled on edge N+1 alongside the push.
   task automatic send_byte(input logic [7:0] b, input bit pop);
      @(negedge clk);
      bus.code = b;
      bus.code_valid = 1'b1;
      @(negedge clk);
      bus.code_valid = 1'b0;
      bus.rd_en = pop;
      @(negedge clk);
      bus.rd_en = 1'b0;
      model_byte(b, pop);
   endtask

   task automatic pop_one();
      @(negedge clk);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.ascii_valid); end
      checks++; if (bus.ascii_out !== 8'h00) begin errors++; $display("FAIL reset_ascii got=%h want=00", bus.ascii_out); end
      checks++; if (bus.key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down got=%b want=0", bus.key_down); end
      checks++; if (bus.held_code !== 8'h00) begin errors++; $display("FAIL reset_held got=%h want=00", bus.held_code); end
      checks++; if (bus.press_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.press_count); end
      checks++; if (bus.overflow !== 1'b0 || bus.fifo_full !== 1'b0 || bus.shift_held !== 1'b0) begin
         errors++; $display("FAIL reset_flags got ovf=%b full=%b shift=%b want all 0", bus.overflow, bus.fifo_full, bus.shift_held);
      end
   endtask

   task automatic test_latency();
      apply_reset();
      @(negedge clk);
      bus.code = 8'h1C;
      bus.code_valid = 1'b1;
      @(negedge clk);
      bus.code_valid = 1'b0;
      checks++; if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b want=0", bus.ascii_valid); end
      @(negedge clk);
      checks++; if (bus.ascii_valid !== 1'b1 || bus.ascii_out !== 8'h41) begin
         errors++; $display("FAIL latency_visible got valid=%b ascii=%h want 1/41", bus.ascii_valid, bus.ascii_out);
      end
   endtask

   task automatic test_make_break();
      apply_reset();
      send_byte(8'h1C, 1'b0);
      checks++; if (bus.key_down !== 1'b1 || bus.held_code !== 8'h1C) begin
         errors++; $display("FAIL make_held got key=%b held=%h want 1/1C", bus.key_down, bus.held_code);
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      checks++; if (bus.key_down !== 1'b0 || bus.held_code !== 8'h00) begin
         errors++; $display("FAIL break_clear got key=%b held=%h want 0/00", bus.key_down, bus.held_code);
      end
      checks++; if (bus.press_count !== 8'd1) begin errors++; $display("FAIL make_count got=%0d want=1", bus.press_count); end
      checks++; if (bus.ascii_out !== 8'h41) begin errors++; $display("FAIL make_ascii got=%h want=41", bus.ascii_out); end
      pop_one();
      checks++; if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL make_single got valid=%b want=0", bus.ascii_valid); end
   endtask

   task automatic test_typematic();
      apply_reset();
      repeat (3) send_byte(8'h1C, 1'b0);
      checks++; if (bus.press_count !== 8'd1) begin errors++; $display("FAIL typematic_count got=%0d want=1", bus.press_count); end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      checks++; if (bus.ascii_out !== 8'h41) begin errors++; $display("FAIL typematic_ascii got=%h want=41", bus.ascii_out); end
      pop_one();
      checks++; if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL typematic_single got valid=%b want=0", bus.ascii_valid); end
   endtask

   task automatic test_extended();
      logic [7:0] seq[5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
      apply_reset();
      for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b0);
      checks++; if (bus.ascii_valid !== 1'b0 || bus.press_count !== 8'd0 || bus.key_down !== 1'b0) begin
         errors++; $display("FAIL ext_ignored got valid=%b cnt=%0d key=%b want 0/0/0", bus.ascii_valid, bus.press_count, bus.key_down);
      end
      send_byte(8'h32, 1'b0);
      checks++; if (bus.ascii_valid !== 1'b1 || bus.ascii_out !== 8'h42) begin
         errors++; $display("FAIL ext_then_make got valid=%b ascii=%h want 1/42", bus.ascii_valid, bus.ascii_out);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes[8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
      logic [7:0] exp[8]   = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
      apply_reset();
      for (int i = 0; i < DEPTH; i++) send_byte(codes[i], 1'b0);
      checks++; if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0) begin
         errors++; $display("FAIL fill got full=%b ovf=%b want 1/0", bus.fifo_full, bus.overflow);
      end
      send_byte(8'h43, 1'b1);
      checks++; if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0 || bus.ascii_out !== 8'h42) begin
         errors++; $display("FAIL push_pop_full got full=%b ovf=%b head=%h want 1/0/42", bus.fifo_full, bus.overflow, bus.ascii_out);
      end
      send_byte(8'h3B, 1'b0);
      checks++; if (bus.overflow !== 1'b1 || bus.press_count !== 8'd10) begin
         errors++; $display("FAIL overflow got ovf=%b cnt=%0d want 1/10", bus.overflow, bus.press_count);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (bus.ascii_valid !== 1'b1 || bus.ascii_out !== exp[i]) begin
            errors++; $display("FAIL readback[%0d] got valid=%b ascii=%h want 1/%h", i, bus.ascii_valid, bus.ascii_out, exp[i]);
         end
         pop_one();
      end
      checks++; if (bus.ascii_valid !== 1'b0 || bus.ascii_out !== 8'h00 || bus.overflow !== 1'b1) begin
         errors++; $display("FAIL drained got valid=%b ascii=%h ovf=%b want 0/00/1", bus.ascii_valid, bus.ascii_out, bus.overflow);
      end
   endtask

   task automatic test_shift();
      logic [7:0] second = SHIFT_CASE ? 8'h61 : 8'h41;
      apply_reset();
      send_byte(8'h12, 1'b0);
      checks++; if (bus.shift_held !== 1'b1 || bus.key_down !== 1'b0) begin
         errors++; $display("FAIL shift_set got shift=%b key=%b want 1/0", bus.shift_held, bus.key_down);
      end
      send_byte(8'h1C, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h12, 1'b0);
      checks++; if (bus.shift_held !== 1'b0) begin errors++; $display("FAIL shift_clear got=%b want=0", bus.shift_held); end
      send_byte(8'h1C, 1'b0);
      checks++; if (bus.ascii_out !== 8'h41) begin errors++; $display("FAIL shift_first got=%h want=41", bus.ascii_out); end
      pop_one();
      checks++; if (bus.ascii_out !== second) begin errors++; $display("FAIL shift_second got=%h want=%h", bus.ascii_out, second); end
      apply_reset();
      send_byte(8'h59, 1'b0);
      send_byte(8'h16, 1'b0);
      checks++; if (bus.ascii_out !== (SHIFT_CASE ? 8'h21 : 8'h31)) begin
         errors++; $display("FAIL shift_digit got=%h want=%h", bus.ascii_out, SHIFT_CASE ? 8'h21 : 8'h31);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      send_byte(8'hF0, 1'b0);
      apply_reset();
      send_byte(8'h1C, 1'b0);
      checks++; if (bus.ascii_out !== 8'h41 || bus.key_down !== 1'b1 || bus.press_count !== 8'd1) begin
         errors++; $display("FAIL reset_mid got ascii=%h key=%b cnt=%0d want 41/1/1", bus.ascii_out, bus.key_down, bus.press_count);
      end
   endtask

   task automatic test_count_wrap();
      apply_reset();
      for (int i = 0; i < 258; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32, 1'b0);
      checks++; if (bus.press_count !== 8'd2) begin errors++; $display("FAIL count_wrap got=%0d want=2", bus.press_count); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         p;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         b = pool[$urandom_range(15, 0)];
         p = ($urandom_range(2, 0) == 0);
         send_byte(b, p);
         checks++;
         if (bus.ascii_valid !== (q.size() > 0) || bus.ascii_out !== ((q.size() > 0) ? q[0] : 8'h00) ||
             bus.key_down !== m_key || bus.held_code !== m_held || bus.shift_held !== m_shift ||
             bus.press_count !== CNT_W'(m_cnt) || bus.overflow !== m_ovf || bus.fifo_full !== (q.size() == DEPTH)) begin
            errors++;
            $display("FAIL random[%0d] byte=%h got v=%b a=%h k=%b h=%h s=%b c=%0d o=%b f=%b want v=%b a=%h k=%b h=%h s=%b c=%0d o=%b f=%b",
                     i, b, bus.ascii_valid, bus.ascii_out, bus.key_down, bus.held_code, bus.shift_held,
                     bus.press_count, bus.overflow, bus.fifo_full, q.size() > 0, (q.size() > 0) ? q[0] : 8'h00,
                     m_key, m_held, m_shift, CNT_W'(m_cnt), m_ovf, q.size() == DEPTH);
         end
      end
   endtask

   initial begin
      bus.code_valid = 1'b0;
      bus.code = 8'h00;
      bus.rd_en = 1'b0;
      test_reset();
      test_latency();
      test_make_break();
      test_typematic();
      test_extended();
      test_overflow();
      test_shift();
      test_reset_mid();
      test_count_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
